// File: rtl/mem_responder.sv
// Single-port word memory slave on a valid/ready bus with configurable response latency.
// Out-of-range accesses answer with mem_err and never touch the array.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             enter_resp;
  logic             ready_d, err_d, rd_en, wr_en;

  logic [31:0]      sel_addr, offset;
  logic [3:0]       sel_wstrb;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  logic [31:0]      mem [DEPTH_WORDS];

  // With zero wait states the response is prepared at the accept edge, so decode the live bus in IDLE.
  assign sel_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
  assign sel_wstrb = (state_q == IDLE) ? mem_wstrb : wstrb_q;
  assign offset    = sel_addr - BASE_ADDR;
  assign in_range  = {1'b0, offset} < LIMIT;
  assign idx       = offset[IDX_W+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    enter_resp = 1'b0;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = '0;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = DONE;
        wr_en   = in_range && (wstrb_q != 4'b0000);
      end
      DONE: begin
        if (!mem_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      ready_d = 1'b1;
      err_d   = !in_range;
      rd_en   = in_range && (sel_wstrb == 4'b0000);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      mem_ready <= ready_d;
      mem_err   <= err_d;
      mem_rdata <= rd_en ? mem[idx] : '0;
    end
  end

  // Array is intentionally not reset; write commits on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (1 wait state at base 0, 0 wait states at a high base).
// Expected responses come from an array model of the memory map.
module tb_mem_responder;

  localparam int unsigned N = 2;
  localparam logic [31:0] BASE1 = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v   [N];
  logic [31:0] a   [N];
  logic [31:0] wd  [N];
  logic [3:0]  ws  [N];
  logic        rdy [N];
  logic [31:0] rd  [N];
  logic        er  [N];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [N][1024];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .reset(reset), .mem_valid(v[0]), .mem_addr(a[0]), .mem_wdata(wd[0]),
    .mem_wstrb(ws[0]), .mem_ready(rdy[0]), .mem_rdata(rd[0]), .mem_err(er[0]));

  mem_responder #(.BASE_ADDR(BASE1), .DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(reset), .mem_valid(v[1]), .mem_addr(a[1]), .mem_wdata(wd[1]),
    .mem_wstrb(ws[1]), .mem_ready(rdy[1]), .mem_rdata(rd[1]), .mem_err(er[1]));

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0000_0000 : BASE1;
  endfunction

  function automatic logic [31:0] bytes_of(input int k);
    return (k == 0) ? 32'd4096 : 32'd64;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit hit(input int k, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - base_of(k);
    return off < bytes_of(k);
  endfunction

  function automatic int widx(input int k, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - base_of(k);
    return int'(off >> 2);
  endfunction

  function automatic exp_t predict(input int k, input logic [31:0] addr, input logic [3:0] strb);
    exp_t e;
    e.rdata = '0;
    e.err   = 1'b0;
    if (!hit(k, addr)) e.err = 1'b1;
    else if (strb == 4'b0000) e.rdata = model[k][widx(k, addr)];
    return e;
  endfunction

  task automatic commit(input int k, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (hit(k, addr)) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[k][widx(k, addr)][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation; idle outputs stay zero.
  task automatic check_out(input int k);
    exp_t e;
    if (rdy[k] === 1'b1) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready dut%0d: got ready=1, expected ready=0 at %0t", k, $time);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("rdata dut%0d", k), rd[k], e.rdata);
        cmp($sformatf("err dut%0d", k), 32'(er[k]), 32'(e.err));
      end
    end else begin
      cmp($sformatf("idle_rdata dut%0d", k), rd[k], 32'h0);
      cmp($sformatf("idle_err dut%0d", k), 32'(er[k]), 32'h0);
    end
  endtask

  always @(negedge clk) check_out(0);
  always @(negedge clk) check_out(1);

  task automatic check_zero_outputs(input int k, input string tag);
    cmp({tag, "_ready"}, 32'(rdy[k]), 32'h0);
    cmp({tag, "_rdata"}, rd[k], 32'h0);
    cmp({tag, "_err"}, 32'(er[k]), 32'h0);
  endtask

  // abort: 0 normal, 1 reset during WAIT, 2 reset during RESP, 3 valid dropped during WAIT.
  // Called and returns at a falling edge.
  task automatic txn(input int k, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input int hold, input int abort);
    exp_t e;
    int   n;
    e = predict(k, addr, strb);
    if (abort == 0 || abort == 2) begin
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (abort == 0 && strb != 4'b0000) commit(k, addr, data, strb);
    v[k] = 1'b1; a[k] = addr; wd[k] = data; ws[k] = strb;
    @(posedge clk);
    if (abort == 1) begin
      #1 reset = 1'b1;
      #1 check_zero_outputs(k, "rst_wait");
      @(negedge clk);
      reset = 1'b0;
      v[k] = 1'b0;
      return;
    end
    @(negedge clk);
    a[k] = $urandom; wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15));
    if (abort == 3) begin
      v[k] = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    n = 1;
    while (rdy[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rdy[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut%0d: got no ready in %0d cycles, expected ready after %0d", k, n, lat_of(k));
      v[k] = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end
    cmp($sformatf("latency dut%0d", k), 32'(n), 32'(lat_of(k)));
    if (abort == 2) begin
      #1 reset = 1'b1;
      #1 check_zero_outputs(k, "rst_resp");
      @(negedge clk);
      reset = 1'b0;
      v[k] = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    v[k] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    for (int k = 0; k < N; k++) begin
      v[k] = 1'b0; a[k] = '0; wd[k] = '0; ws[k] = '0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Full write, readback, then a single-lane update.
    txn(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0);
    txn(0, 32'h10, 32'h0000_5500, 4'b0010, 0, 0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, 0);
    cmp("lane_model_word", model[0][4], 32'hDEAD_55EF);

    // Out-of-range read/write at the first address past the array.
    txn(0, 32'h0, 32'hA5A5_0001, 4'hF, 0, 0);
    txn(0, 32'h1000, 32'h0, 4'h0, 0, 0);
    txn(0, 32'h1000, 32'hFFFF_FFFF, 4'hF, 1, 0);
    txn(0, 32'h0, 32'h0, 4'h0, 0, 0);

    // Zero wait states with valid held after ready: one pulse only.
    txn(1, BASE1 + 32'h4, 32'h1234_5678, 4'hF, 3, 0);
    txn(1, BASE1 + 32'h4, 32'h0, 4'h0, 3, 0);

    // Reset during WAIT of a write.
    txn(0, 32'h20, 32'h1111_1111, 4'hF, 0, 0);
    txn(0, 32'h20, 32'h9999_9999, 4'hF, 0, 1);
    txn(0, 32'h20, 32'h0, 4'h0, 0, 0);

    // Reset during RESP of a write, then during RESP of a read.
    txn(0, 32'h24, 32'h2222_2222, 4'hF, 0, 0);
    txn(0, 32'h24, 32'h3333_3333, 4'hF, 0, 2);
    txn(0, 32'h24, 32'h0, 4'h0, 0, 2);
    txn(0, 32'h24, 32'h0, 4'h0, 0, 0);

    // Valid dropped in WAIT discards the write.
    txn(0, 32'h28, 32'h4444_4444, 4'hF, 0, 0);
    txn(0, 32'h28, 32'h5555_5555, 4'hF, 0, 3);
    txn(0, 32'h28, 32'h0, 4'h0, 0, 0);

    // Boundaries of the high-based instance: below base, last word, one past end.
    txn(1, BASE1 - 32'h4, 32'h0, 4'h0, 0, 0);
    txn(1, BASE1 + 32'h3C, 32'hCAFE_F00D, 4'hF, 0, 0);
    txn(1, BASE1 + 32'h3C, 32'h0, 4'h0, 0, 0);
    txn(1, BASE1 + 32'h40, 32'h0, 4'h0, 0, 0);
    txn(1, BASE1 + 32'h40, 32'h0BAD_0BAD, 4'hF, 0, 0);

    // Randomized alternating writes/reads over words 0..7 of both instances.
    for (int k = 0; k < N; k++) begin
      b = base_of(k);
      for (int i = 0; i < 8; i++) txn(k, b + 32'(4 * i), $urandom, 4'hF, 0, 0);
    end
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) begin
        b = base_of(k);
        for (int i = 0; i < 8; i++) begin
          if (i % 2 == 0)
            txn(k, b + 32'(4 * $urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 2)), 0);
          else
            txn(k, b + 32'(4 * $urandom_range(0, 7)), 32'h0, 4'h0, int'($urandom_range(0, 2)), 0);
        end
      end
    end

    repeat (4) @(negedge clk);
    cmp("pending_dut0", 32'(q0.size()), 32'h0);
    cmp("pending_dut1", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 of the local array.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words; power of two, >= 2.
REQ-003 SHALL have parameter WAIT_STATES, default 1, extra cycles between accept and response; range 0..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 mem_valid  input  1  initiator request strobe; held high until mem_ready.
REQ-007 mem_addr  input  32  byte address; bits [1:0] ignored (word access).
REQ-008 mem_wdata  input  32  lane-aligned write data.
REQ-009 mem_wstrb  input  4  byte-lane write enables; 4'b0000 = read, nonzero = write.
REQ-010 mem_ready  output  1  one-cycle response strobe.
REQ-011 mem_rdata  output  32  read word, valid only while mem_ready=1.
REQ-012 mem_err  output  1  access fault flag, valid only while mem_ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP, DONE.
REQ-014 IDLE: mem_valid=1 -> latch addr/wdata/wstrb, clear wait counter; go WAIT if WAIT_STATES>0, else RESP.
REQ-015 WAIT: counter increments each cycle; after WAIT_STATES cycles in WAIT go RESP.
REQ-016 RESP: mem_ready=1 for exactly one cycle; next state DONE.
REQ-017 DONE: stay until mem_valid=0, then IDLE; prevents re-accepting a request the initiator has not yet dropped.
REQ-018 Latency: mem_ready SHALL rise exactly WAIT_STATES+1 cycles after the edge at which IDLE sampled mem_valid=1.
REQ-019 In-range test: (addr - BASE_ADDR), 32-bit unsigned, < DEPTH_WORDS*4; word index = bits [log2(DEPTH_WORDS)+1:2] of that offset.
REQ-020 In-range write: on the RESP edge, each lane i with wstrb[i]=1 SHALL take wdata[8i+7:8i]; other lanes are unchanged.
REQ-021 In-range read: mem_rdata SHALL equal the addressed word during RESP; mem_err=0.
REQ-022 Out-of-range access: mem_err=1 and mem_rdata=0 during RESP; no array write.
REQ-023 mem_rdata and mem_err SHALL be 0 in every cycle with mem_ready=0.
REQ-024 If mem_valid falls in WAIT (protocol violation), SHALL go to IDLE, discard request, no write, no mem_ready.
REQ-025 Read of a word written by the previous transaction SHALL return the new data (no stale read).
REQ-026 Request inputs SHALL NOT be resampled after IDLE; later changes before mem_ready have no effect.

Reset
REQ-027 reset=1 SHALL asynchronously force state IDLE, wait counter 0, mem_ready=0, mem_err=0, mem_rdata=0, latched request cleared.
REQ-028 Reset mid-transaction (WAIT or RESP) SHALL abort; pending write not committed.
REQ-029 Array contents are not reset and are undefined until written.
REQ-030 First request is accepted on the first rising edge after reset deasserts.

Verification
REQ-031 WAIT_STATES=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> mem_ready on 2nd cycle after accept, mem_err=0; then read 0x10 -> mem_rdata=0xDEADBEEF.
REQ-032 Byte lanes: after REQ-031, write 0x10, wdata 0x0000_5500, wstrb 4'b0010 -> read 0x10 returns 0xDEAD55EF.
REQ-033 Out of range: DEPTH_WORDS=1024, BASE_ADDR=0, read 0x1000 -> mem_ready with mem_err=1, mem_rdata=0; write 0x1000 leaves word 0 unchanged.
REQ-034 WAIT_STATES=0 with valid held 3 cycles after ready -> exactly one mem_ready pulse, one cycle after accept; no second accept until valid drops.
REQ-035 Reset asserted in WAIT of a write to 0x20 (prior data 0x11111111) -> outputs 0 immediately; subsequent read of 0x20 returns 0x11111111.
REQ-036 Back-to-back: 8 alternating writes/reads to 0x0..0x1C with random wstrb -> every read matches scoreboard; mem_rdata=0 whenever mem_ready=0.
